// File: rtl/bin2bcd_seq_if.sv
// Handshake/bus bundle for bin2bcd_seq.
//   start_i : conversion request (master -> converter)
//   bin_i   : unsigned binary value, WIDTH bits (master -> converter)
//   busy_o  : conversion in progress (converter -> master)
//   done_o  : one-cycle result-valid pulse (converter -> master)
//   bcd_o   : packed BCD result, 4*DIGITS bits, units in [3:0] (converter -> master)
//   ovf_o   : last value exceeded 10^DIGITS-1 (converter -> master)
interface bin2bcd_seq_if #(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DIGITS = 3
);
    logic                  start_i;
    logic [WIDTH-1:0]      bin_i;
    logic                  busy_o;
    logic                  done_o;
    logic [4*DIGITS-1:0]   bcd_o;
    logic                  ovf_o;

    modport master (
        output start_i, bin_i,
        input  busy_o, done_o, bcd_o, ovf_o
    );

    modport slave (
        input  start_i, bin_i,
        output busy_o, done_o, bcd_o, ovf_o
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, shift-and-add-3, one bit per clock.
//   clk_i   : clock, rising edge
//   rst_n_i : synchronous active-low reset
//   bus     : bin2bcd_seq_if slave (start/bin in, busy/done/bcd/ovf out)
// Results saturate to all nines when the value does not fit in DIGITS digits.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    bin2bcd_seq_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned SH_W  = BCD_W + WIDTH;
    localparam logic [BCD_W-1:0] NINES = {DIGITS{4'd9}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   adj;
    logic [SH_W-1:0]    shifted;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            bin_q   <= '0;
            dig_q   <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        dig_d   = dig_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        adj     = '0;
        shifted = '0;

        // Per-digit add-3, no carry between digits
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ? dig_q[4*i +: 4] + 4'd3
                                                      : dig_q[4*i +: 4];
        end
        shifted = {adj, bin_q} << 1;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = SHIFT;
                    bin_d   = bus.bin_i;
                    dig_d   = '0;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                dig_d = shifted[SH_W-1 -: BCD_W];
                bin_d = shifted[WIDTH-1:0];
                // Bit shifted out of the top digit means the value does not fit
                acc_d = acc_q | adj[BCD_W-1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    ovf_d   = acc_d;
                    bcd_d   = acc_d ? NINES : shifted[SH_W-1 -: BCD_W];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.bcd_o  = bcd_q;
    assign bus.ovf_o  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 3-digit and a 2-digit instance sharing clock/reset.
module tb_bin2bcd_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bin2bcd_seq_if #(.WIDTH(9), .DIGITS(3)) if0 ();
    bin2bcd_seq_if #(.WIDTH(9), .DIGITS(2)) if1 ();

    bin2bcd_seq #(.WIDTH(9), .DIGITS(3)) u0 (.clk_i(clk), .rst_n_i(rst_n), .bus(if0));
    bin2bcd_seq #(.WIDTH(9), .DIGITS(2)) u1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start a conversion on the 3-digit unit; return results sampled at done.
    task automatic run0(input logic [8:0] v, output logic [11:0] bcd, output logic ovf);
        int n;
        if0.start_i = 1'b1;
        if0.bin_i   = v;
        tick();
        if0.start_i = 1'b0;
        n = 1;
        while (!if0.done_o && n < 30) begin
            tick();
            n++;
        end
        chk("run0_latency", 32'(n), 32'd10);
        bcd = if0.bcd_o;
        ovf = if0.ovf_o;
        tick();
    endtask

    task automatic run1(input logic [8:0] v, output logic [7:0] bcd, output logic ovf);
        int n;
        if1.start_i = 1'b1;
        if1.bin_i   = v;
        tick();
        if1.start_i = 1'b0;
        n = 1;
        while (!if1.done_o && n < 30) begin
            tick();
            n++;
        end
        chk("run1_latency", 32'(n), 32'd10);
        bcd = if1.bcd_o;
        ovf = if1.ovf_o;
        tick();
    endtask

    initial begin
        logic [11:0] b3;
        logic [7:0]  b2;
        logic        ov;
        int          n;
        int          ndone;
        int          rises[$];
        logic        prev_busy;
        int          a;
        int          b;
        int          dec;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        if0.start_i = 1'b0;
        if0.bin_i   = '0;
        if1.start_i = 1'b0;
        if1.bin_i   = '0;
        tick();
        tick();
        chk("rst_busy", 32'(if0.busy_o), 32'd0);
        chk("rst_done", 32'(if0.done_o), 32'd0);
        chk("rst_bcd",  32'(if0.bcd_o),  32'd0);
        chk("rst_ovf",  32'(if0.ovf_o),  32'd0);

        // start together with reset is not accepted
        if0.start_i = 1'b1;
        tick();
        if0.start_i = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst_start_busy", 32'(if0.busy_o), 32'd0);

        // zero: busy cycles 1..9, done only in cycle 10
        if0.start_i = 1'b1;
        if0.bin_i   = 9'd0;
        tick();
        if0.start_i = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("zero_busy_c%0d", c), 32'(if0.busy_o), 32'd1);
            chk($sformatf("zero_done_c%0d", c), 32'(if0.done_o), 32'd0);
            tick();
        end
        chk("zero_done_c10", 32'(if0.done_o), 32'd1);
        chk("zero_busy_c10", 32'(if0.busy_o), 32'd0);
        chk("zero_bcd",      32'(if0.bcd_o),  32'h000);
        chk("zero_ovf",      32'(if0.ovf_o),  32'd0);
        tick();
        chk("zero_done_c11", 32'(if0.done_o), 32'd0);

        // 510 with bin_i disturbed in cycle 3
        if0.start_i = 1'b1;
        if0.bin_i   = 9'd510;
        tick();
        if0.start_i = 1'b0;
        n = 1;
        while (!if0.done_o && n < 30) begin
            if (n == 3) if0.bin_i = 9'd7;
            tick();
            n++;
        end
        chk("510_latency", 32'(n), 32'd10);
        chk("510_bcd",     32'(if0.bcd_o), 32'h510);
        chk("510_ovf",     32'(if0.ovf_o), 32'd0);
        repeat (20) tick();
        chk("510_hold", 32'(if0.bcd_o), 32'h510);

        // start held high: accepts every 11 cycles
        if0.start_i = 1'b1;
        if0.bin_i   = 9'd255;
        prev_busy   = 1'b0;
        ndone       = 0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (if0.busy_o && !prev_busy) rises.push_back(k);
            if (if0.done_o) begin
                ndone++;
                chk("held_bcd", 32'(if0.bcd_o), 32'h255);
            end
            prev_busy = if0.busy_o;
        end
        if0.start_i = 1'b0;
        chk("held_ndone",  32'(ndone),       32'd4);
        chk("held_nrises", 32'(rises.size()), 32'd5);
        for (int i = 1; i < rises.size(); i++)
            chk("held_period", 32'(rises[i] - rises[i-1]), 32'd11);
        n = 0;
        while (!if0.done_o && n < 30) begin
            tick();
            n++;
        end
        chk("held_tail_done", 32'(if0.done_o), 32'd1);
        tick();

        // start pulse during busy is dropped
        if0.start_i = 1'b1;
        if0.bin_i   = 9'd255;
        tick();
        if0.start_i = 1'b0;
        tick();
        tick();
        if0.start_i = 1'b1;
        if0.bin_i   = 9'd5;
        tick();
        if0.start_i = 1'b0;
        n = 4;
        while (!if0.done_o && n < 30) begin
            tick();
            n++;
        end
        chk("busy_start_lat", 32'(n), 32'd10);
        chk("busy_start_bcd", 32'(if0.bcd_o), 32'h255);
        tick();
        tick();
        chk("busy_start_dropped", 32'(if0.busy_o), 32'd0);

        // reset in cycle 5 of a conversion of 300
        if0.start_i = 1'b1;
        if0.bin_i   = 9'd300;
        tick();
        if0.start_i = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 32'(if0.busy_o), 32'd0);
        chk("abort_done", 32'(if0.done_o), 32'd0);
        chk("abort_bcd",  32'(if0.bcd_o),  32'd0);
        chk("abort_ovf",  32'(if0.ovf_o),  32'd0);
        ndone = 0;
        repeat (15) begin
            tick();
            if (if0.done_o) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run0(9'd42, b3, ov);
        chk("42_bcd", 32'(b3), 32'h042);
        chk("42_ovf", 32'(ov), 32'd0);

        // 2-digit unit: saturation and exact fit
        run1(9'd100, b2, ov);
        chk("d2_100_ovf", 32'(ov), 32'd1);
        chk("d2_100_bcd", 32'(b2), 32'h99);
        run1(9'd99, b2, ov);
        chk("d2_99_ovf", 32'(ov), 32'd0);
        chk("d2_99_bcd", 32'(b2), 32'h99);

        // adder sums a+b of two 8-bit operands
        for (int v = 0; v < 10; v++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run0(9'(a + b), b3, ov);
            dec = int'(b3[11:8]) * 100 + int'(b3[7:4]) * 10 + int'(b3[3:0]);
            if (dec == a + b && !ov) $display("Test approved: %0d + %0d = %0h", a, b, b3);
            else                     $display("Erro: %0d + %0d -> %0h", a, b, b3);
            chk($sformatf("sum_%0d", v), 32'(dec), 32'(a + b));
            chk($sformatf("sum_ovf_%0d", v), 32'(ov), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
